// File: rtl/cell_plotter.sv
// cell_plotter: pixel-write engine that sits between the Life core and vga_adapter.
//
// Cell-change events (x, y, alive) arrive over a valid/ready handshake.
// Events whose coordinates are on screen are buffered in a small FIFO.
// Events whose coordinates are off screen are consumed and counted.
// The FIFO drains at one vga_adapter plot per clock.
// A clear request flushes the FIFO and sweeps every pixel with the dead colour.
//
// Ports
//   clock, reset        : system clock; synchronous active-high reset
//   in_valid/in_ready   : event handshake (in_ready is combinational)
//   in_x, in_y, in_alive: event payload (legal x 0..159, y 0..119)
//   clear_req           : one-cycle request to blank the screen
//   busy                : registered; clear running, FIFO non-empty or plot high
//   drop_count          : saturating count of out-of-range events
//   x, y, colour, plot  : registered drive for vga_adapter
module cell_plotter #(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [2:0] ALIVE_COLOUR = 3'b111,
  parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic       in_alive,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] drop_count,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int         PTR_W  = $clog2(FIFO_DEPTH);
  localparam int         CNT_W  = PTR_W + 1;
  localparam logic [7:0] X_LAST = 8'd159;
  localparam logic [6:0] Y_LAST = 7'd119;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t           state_reg, state_next;

  // FIFO entry layout: {x[7:0], y[6:0], alive}
  logic [15:0]      mem [FIFO_DEPTH];
  logic [15:0]      rd_entry;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [7:0]       sweep_x_reg;
  logic [6:0]       sweep_y_reg;

  logic [7:0]       x_reg, x_next;
  logic [6:0]       y_reg, y_next;
  logic [2:0]       colour_reg, colour_next;
  logic             plot_reg, plot_next;
  logic             busy_reg, busy_next;
  logic [7:0]       drop_count_reg;

  logic             full, clear_take, accept, in_range, push, drop, pop, sweep_last;

  assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
  // A clear can only start outside a sweep; during a sweep the request is ignored.
  assign clear_take = clear_req && (state_reg != CLEAR);
  // clear_req wins over a same-cycle event, so the event is refused rather than flushed.
  assign in_ready   = !reset && !full && (state_reg != CLEAR) && !clear_req;
  assign accept     = in_valid && in_ready;
  assign in_range   = (in_x < 8'd160) && (in_y < 7'd120);
  assign push       = accept && in_range;
  assign drop       = accept && !in_range;
  // No pop on the clear edge: queued entries are discarded, never plotted.
  assign pop        = (count_reg != '0) && (state_reg != CLEAR) && !clear_take;
  assign sweep_last = (sweep_x_reg == X_LAST) && (sweep_y_reg == Y_LAST);
  assign rd_entry   = mem[rd_ptr_reg];

  // Next-state, occupancy and output selection.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    plot_next   = 1'b0;

    if (clear_take) begin
      state_next = CLEAR;
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if (state_reg == CLEAR) begin
        state_next = sweep_last ? IDLE : CLEAR;
      end else begin
        state_next = (count_next != '0) ? DRAIN : IDLE;
      end
    end

    if (state_reg == CLEAR) begin
      plot_next   = 1'b1;
      x_next      = sweep_x_reg;
      y_next      = sweep_y_reg;
      colour_next = DEAD_COLOUR;
    end else if (pop) begin
      plot_next   = 1'b1;
      x_next      = rd_entry[15:8];
      y_next      = rd_entry[7:1];
      colour_next = rd_entry[0] ? ALIVE_COLOUR : DEAD_COLOUR;
    end

    busy_next = (state_next == CLEAR) || (count_next != '0) || plot_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      sweep_x_reg    <= '0;
      sweep_y_reg    <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      colour_reg     <= '0;
      plot_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= plot_next;
      busy_reg   <= busy_next;

      if (clear_take) begin
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
        sweep_x_reg <= '0;
        sweep_y_reg <= '0;
      end else begin
        // Pointers wrap naturally because the depth is a power of two.
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (state_reg == CLEAR) begin
          // x is the inner loop; y advances at the end of each row.
          if (sweep_x_reg == X_LAST) begin
            sweep_x_reg <= '0;
            sweep_y_reg <= sweep_last ? 7'd0 : sweep_y_reg + 1'b1;
          end else begin
            sweep_x_reg <= sweep_x_reg + 1'b1;
          end
        end
      end

      if (drop && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 1'b1;
      end
    end
  end

  // Storage has no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_x, in_y, in_alive};
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign colour     = colour_reg;
  assign plot       = plot_reg;
  assign busy       = busy_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_cell_plotter.sv
// Testbench for cell_plotter.
// The bench combines three kinds of stimulus:
//   - a table of hand-derived vectors;
//   - randomized traffic compared against a queue-based reference model;
//   - hand-written multi-cycle sequences (clear sweep, clear vs. event, mid-sweep reset).
module tb_cell_plotter;

  localparam int DEPTH  = 8;
  localparam int PIXELS = 160 * 120;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = '0;
  logic [6:0] in_y = '0;
  logic       in_alive = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [7:0] drop_count;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  cell_plotter #(
    .FIFO_DEPTH  (DEPTH),
    .ALIVE_COLOUR(3'b111),
    .DEAD_COLOUR (3'b000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_alive  (in_alive),
    .clear_req (clear_req),
    .busy      (busy),
    .drop_count(drop_count),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Values sampled from the DUT by the most recent cycle.
  logic       r_ready, r_plot, r_busy;
  logic [7:0] r_x, r_drop;
  logic [6:0] r_y;
  logic [2:0] r_col;

  // Reference model: the event queue, the sweep progress and the expected outputs.
  logic [15:0] m_q[$];
  bit          m_clearing = 0;
  int          m_idx = 0;
  int          m_drop = 0;
  bit          m_plot = 0;
  bit          m_busy = 0;
  int          m_x = 0, m_y = 0, m_col = 0;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_step(logic v, logic [7:0] ix, logic [6:0] iy, logic ia,
                                     logic cr, logic rs, logic rdy);
    logic [15:0] e;
    if (rs) begin
      m_q.delete();
      m_clearing = 0; m_drop = 0; m_plot = 0; m_busy = 0;
      m_x = 0; m_y = 0; m_col = 0;
      return;
    end
    if (!m_clearing && cr) begin
      m_q.delete();
      m_clearing = 1;
      m_idx = 0;
      m_plot = 0;
    end else if (m_clearing) begin
      m_plot = 1;
      m_x = m_idx % 160;
      m_y = m_idx / 160;
      m_col = 0;
      m_idx++;
      if (m_idx == PIXELS) m_clearing = 0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_plot = 1;
      m_x = int'(e[15:8]);
      m_y = int'(e[7:1]);
      m_col = e[0] ? 7 : 0;
    end else begin
      m_plot = 0;
    end
    if (v && rdy) begin
      if (ix < 160 && iy < 120) m_q.push_back({ix, iy, ia});
      else if (m_drop < 255) m_drop++;
    end
    m_busy = m_clearing || (m_q.size() > 0) || m_plot;
  endfunction

  // One clock: drive inputs after the falling edge, check in_ready,
  // then check registered outputs 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] ix, input logic [6:0] iy,
                       input logic ia, input logic cr, input logic rs);
    logic exp_ready;
    @(negedge clock);
    in_valid = v; in_x = ix; in_y = iy; in_alive = ia; clear_req = cr; reset = rs;
    #1;
    r_ready   = in_ready;
    exp_ready = !rs && (m_q.size() < DEPTH) && !m_clearing && !cr;
    chk("model in_ready", int'(r_ready), int'(exp_ready));
    model_step(v, ix, iy, ia, cr, rs, exp_ready);
    @(posedge clock);
    cyc++;
    #1;
    r_plot = plot; r_busy = busy; r_x = x; r_y = y; r_col = colour; r_drop = drop_count;
    chk("model plot", int'(r_plot), int'(m_plot));
    chk("model busy", int'(r_busy), int'(m_busy));
    chk("model drop_count", int'(r_drop), m_drop);
    if (m_plot) begin
      chk("model x", int'(r_x), m_x);
      chk("model y", int'(r_y), m_y);
      chk("model colour", int'(r_col), m_col);
    end
    if (n_err >= 40) begin
      $display("FAIL abort: stopping after %0d miscompares", n_err);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] ix;
    logic [6:0] iy;
    logic       ia;
    logic       e_ready;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    int         e_drop;
  } vec_t;

  vec_t tbl[13];

  typedef struct {
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ea;
  } ev_t;

  ev_t evs[12];

  initial begin
    int sweep_pl, ready_hi, first_acc, p, n_pl, k;
    logic [7:0] bx;
    logic [6:0] by;

    // Each row: inputs for one cycle, then the outputs expected after that edge.
    tbl[0]  = '{1'b1, 8'd5,   7'd7,   1'b1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 0};
    tbl[1]  = '{1'b0, 8'd0,   7'd0,   1'b0, 1'b1, 1'b1, 8'd5,   7'd7,   3'd7, 0};
    tbl[2]  = '{1'b0, 8'd0,   7'd0,   1'b0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 0};
    tbl[3]  = '{1'b1, 8'd160, 7'd0,   1'b1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 1};
    tbl[4]  = '{1'b1, 8'd0,   7'd120, 1'b1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 2};
    tbl[5]  = '{1'b1, 8'd255, 7'd127, 1'b0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 3};
    tbl[6]  = '{1'b1, 8'd9,   7'd9,   1'b1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 3};
    tbl[7]  = '{1'b1, 8'd9,   7'd9,   1'b0, 1'b1, 1'b1, 8'd9,   7'd9,   3'd7, 3};
    tbl[8]  = '{1'b0, 8'd0,   7'd0,   1'b0, 1'b1, 1'b1, 8'd9,   7'd9,   3'd0, 3};
    tbl[9]  = '{1'b1, 8'd159, 7'd119, 1'b1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 3};
    tbl[10] = '{1'b1, 8'd0,   7'd0,   1'b0, 1'b1, 1'b1, 8'd159, 7'd119, 3'd7, 3};
    tbl[11] = '{1'b0, 8'd0,   7'd0,   1'b0, 1'b1, 1'b1, 8'd0,   7'd0,   3'd0, 3};
    tbl[12] = '{1'b0, 8'd0,   7'd0,   1'b0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 3};

    for (int j = 0; j < 12; j++) begin
      evs[j].ex = 8'(10 + 3 * j);
      evs[j].ey = 7'(5 + 2 * j);
      evs[j].ea = 1'(j % 2);
    end

    // Reset state.
    cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'd1, 7'd1, 1'b1, 1'b0, 1'b1);
    chk("reset in_ready", int'(r_ready), 0);
    chk("reset x", int'(r_x), 0);
    chk("reset y", int'(r_y), 0);
    chk("reset colour", int'(r_col), 0);
    chk("reset plot", int'(r_plot), 0);
    chk("reset busy", int'(r_busy), 0);
    chk("reset drop_count", int'(r_drop), 0);
    $display("reset: plot=%0d busy=%0d drop=%0d", r_plot, r_busy, r_drop);

    // Table vectors: single event, range drops, duplicates, back-to-back events.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].ix, tbl[i].iy, tbl[i].ia, 1'b0, 1'b0);
      chk($sformatf("tbl[%0d] in_ready", i), int'(r_ready), int'(tbl[i].e_ready));
      chk($sformatf("tbl[%0d] plot", i), int'(r_plot), int'(tbl[i].e_plot));
      chk($sformatf("tbl[%0d] drop_count", i), int'(r_drop), tbl[i].e_drop);
      if (tbl[i].e_plot) begin
        chk($sformatf("tbl[%0d] x", i), int'(r_x), int'(tbl[i].e_x));
        chk($sformatf("tbl[%0d] y", i), int'(r_y), int'(tbl[i].e_y));
        chk($sformatf("tbl[%0d] colour", i), int'(r_col), int'(tbl[i].e_col));
      end
      $display("vec %0d: in=(%0d,%0d,%0d) v=%0d -> plot=%0d (%0d,%0d) c=%0d drop=%0d",
               i, tbl[i].ix, tbl[i].iy, tbl[i].ia, tbl[i].v, r_plot, r_x, r_y, r_col, r_drop);
    end

    // Randomized traffic against the model (mostly legal, some off-screen).
    for (int i = 0; i < 400; i++) begin
      bx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
      by = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
      cycle(1'($urandom_range(0, 3) != 0), bx, by, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    idle(2);
    $display("random: drop=%0d busy=%0d", r_drop, r_busy);

    // drop_count saturation with 300 bad events.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 8'($urandom_range(160, 255)), 7'($urandom_range(0, 127)), 1'b1, 1'b0, 1'b0);
    end
    idle(1);
    chk("drop saturation", int'(r_drop), 255);
    $display("saturation: drop=%0d", r_drop);

    // Full clear sweep, with a repeated clear_req in mid-sweep that must be ignored.
    sweep_pl = 0; ready_hi = 0;
    cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    chk("clear edge plot", int'(r_plot), 0);
    for (int i = 1; i <= PIXELS + 1; i++) begin
      cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'(i == 100), 1'b0);
      if (i <= PIXELS) begin
        if (r_plot && r_col == 3'd0) sweep_pl++;
        if (r_ready) ready_hi++;
      end
      if (i == 1) begin
        chk("sweep first plot", int'(r_plot), 1);
        chk("sweep first x", int'(r_x), 0);
        chk("sweep first y", int'(r_y), 0);
      end
      if (i == PIXELS) begin
        chk("sweep last x", int'(r_x), 159);
        chk("sweep last y", int'(r_y), 119);
        chk("sweep last busy", int'(r_busy), 1);
      end
      if (i == PIXELS + 1) begin
        chk("post-sweep plot", int'(r_plot), 0);
        chk("post-sweep busy", int'(r_busy), 0);
        chk("post-sweep in_ready", int'(r_ready), 1);
      end
    end
    chk("sweep plot count", sweep_pl, PIXELS);
    chk("sweep in_ready highs", ready_hi, 0);
    $display("sweep: plots=%0d ready_highs=%0d", sweep_pl, ready_hi);

    // clear_req together with in_valid while an entry is queued, then 12 events
    // held valid through the sweep and plotted in order once it ends.
    cycle(1'b1, 8'd20, 7'd30, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'd21, 7'd31, 1'b0, 1'b1, 1'b0);
    chk("clear+event in_ready", int'(r_ready), 0);
    chk("clear+event plot", int'(r_plot), 0);
    p = 0; n_pl = 0; first_acc = -1;
    for (int i = 1; i <= PIXELS + 40 && n_pl < 12; i++) begin
      k = (p < 12) ? p : 0;
      cycle(1'(p < 12), evs[k].ex, evs[k].ey, evs[k].ea, 1'b0, 1'b0);
      if (p < 12 && r_ready) begin
        if (first_acc < 0) first_acc = i;
        p++;
      end
      if (i > PIXELS && r_plot) begin
        chk($sformatf("order[%0d] x", n_pl), int'(r_x), int'(evs[n_pl].ex));
        chk($sformatf("order[%0d] y", n_pl), int'(r_y), int'(evs[n_pl].ey));
        chk($sformatf("order[%0d] colour", n_pl), int'(r_col), evs[n_pl].ea ? 7 : 0);
        $display("event %0d plotted at (%0d,%0d) colour=%0d", n_pl, r_x, r_y, r_col);
        n_pl++;
      end
    end
    chk("held events plotted", n_pl, 12);
    chk("first accept after sweep", first_acc, PIXELS + 1);

    // Reset in the middle of a sweep.
    idle(3);
    cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    idle(500);
    cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    chk("mid-reset plot", int'(r_plot), 0);
    chk("mid-reset busy", int'(r_busy), 0);
    cycle(1'b1, 8'd3, 7'd4, 1'b1, 1'b0, 1'b0);
    chk("after-reset in_ready", int'(r_ready), 1);
    cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    chk("after-reset event plot", int'(r_plot), 1);
    chk("after-reset event x", int'(r_x), 3);
    chk("after-reset event y", int'(r_y), 4);
    cycle(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    chk("after-reset single plot", int'(r_plot), 0);
    $display("mid-reset: plot=%0d busy=%0d", r_plot, r_busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
